i2s_receiver: RTL and testbench

- I2S slave receiver: the capture end of the serial link driven by i2s_transmitter and clock_generator.
- Samples external BCLK, LRCLK and SDATA in the clk_i domain.
- Deserialises the 24-bit left and right words, MSB first, with the standard 1-bit I2S delay.
- Presents each stereo pair on a parallel valid/ready interface for downstream DSP or loopback checking.

---
 rtl/i2s_receiver.sv | 166 ++++++++++++++++
 tb/tb_i2s_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronises BCLK/LRCLK/SDATA into clk_i, deserialises 24-bit
// left/right words (MSB first, one-bit delay) and offers each stereo pair on valid/ready.
module i2s_receiver #(
    parameter logic [7:0] REC_AUDIO_FRAME_LEN = 8'd64,
    parameter logic [7:0] REC_AUDIO_WORD_LEN  = 8'd24,
    parameter int         SYNC_STAGES         = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          audio_bclk_i,
    input  logic                          audio_lrclk_i,
    input  logic                          audio_data_i,
    output logic [REC_AUDIO_WORD_LEN-1:0] left_o,
    output logic [REC_AUDIO_WORD_LEN-1:0] right_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overrun_o,
    output logic                          frame_err_o
);
    localparam int         WL        = int'(REC_AUDIO_WORD_LEN);
    localparam logic [7:0] HALF_LAST = REC_AUDIO_FRAME_LEN / 8'd2 - 8'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, data_sync_q;
    logic                   bclk_prev_q;
    logic                   bclk_s, lr_s, data_s, bclk_rise, lr_edge;

    logic [1:0]    state_q, state_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic [WL-1:0] shift_q, shift_d;
    logic [WL-1:0] shadow_q, shadow_d;
    logic          lr_q, lr_d;
    logic          publish, err_pulse;

    logic [WL-1:0] left_q, right_q;
    logic          valid_q, overrun_q, frame_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            data_sync_q <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], audio_bclk_i};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], audio_lrclk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], audio_data_i};
            bclk_prev_q <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s      = lr_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign lr_edge   = lr_s != lr_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        lr_d      = lr_q;
        publish   = 1'b0;
        err_pulse = 1'b0;
        if (bclk_rise) begin
            lr_d = lr_s;
            // Slot index of this rise is bit_cnt_q+1; slots 1..WL carry data.
            if (lr_edge) begin
                bit_cnt_d = 8'd0;
                shift_d   = '0;
            end else begin
                if (bit_cnt_q != 8'hFF) bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q < REC_AUDIO_WORD_LEN) shift_d = {shift_q[WL-2:0], data_s};
            end
            case (state_q)
                ST_IDLE: begin
                    if (lr_edge && !lr_s) state_d = ST_LEFT;
                end
                ST_LEFT: begin
                    if (lr_edge && lr_s) begin
                        if (bit_cnt_q == HALF_LAST) begin
                            shadow_d = shift_q;
                            state_d  = ST_RIGHT;
                        end else begin
                            err_pulse = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_RIGHT: begin
                    if (lr_edge && !lr_s) begin
                        if (bit_cnt_q == HALF_LAST) begin
                            publish = 1'b1;
                            state_d = ST_LEFT;
                        end else begin
                            err_pulse = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // lr_q keeps tracking while disabled so re-enable waits for a genuine falling edge.
        if (!enable_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 8'd0;
            shift_d   = '0;
            publish   = 1'b0;
            err_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 8'd0;
            shift_q   <= '0;
            shadow_q  <= '0;
            lr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            lr_q      <= lr_d;
        end
    end

    // A new pair is loaded only when the slot is empty or being emptied this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= err_pulse;
            if (publish) begin
                if (!valid_q || ready_i) begin
                    left_q  <= shadow_q;
                    right_q <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: an I2S bit-level driver feeds frames, and observed transfers
// are compared against a pair-level model of what a correct receiver must deliver.
module tb_i2s_receiver;
    localparam int W    = 24;
    localparam int HALF = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         audio_bclk_i;
    logic         audio_lrclk_i;
    logic         audio_data_i;
    logic [W-1:0] left_o;
    logic [W-1:0] right_o;
    logic         valid_o;
    logic         ready_i;
    logic         overrun_o;
    logic         frame_err_o;

    int checks = 0;
    int errors = 0;
    int ovr_cnt, ferr_cnt, valid_hi;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] got_q[$];

    i2s_receiver dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .audio_bclk_i (audio_bclk_i),
        .audio_lrclk_i(audio_lrclk_i),
        .audio_data_i (audio_data_i),
        .left_o       (left_o),
        .right_o      (right_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Observation of the output side, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && ready_i) got_q.push_back({left_o, right_o});
            if (overrun_o) ovr_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (valid_o) valid_hi++;
        end
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        ovr_cnt  = 0;
        ferr_cnt = 0;
        valid_hi = 0;
    endtask

    // One BCLK period: LRCLK and data change on the falling edge, receiver samples on the rise.
    task automatic send_slot(input logic lr, input logic d);
        audio_bclk_i  = 1'b0;
        audio_lrclk_i = lr;
        audio_data_i  = d;
        #23;
        audio_bclk_i = 1'b1;
        #23;
    endtask

    // Slot 0 is the delay bit, slots 1..W carry the word MSB first, the rest are don't-care.
    task automatic send_half(input logic lr, input logic [W-1:0] w, input int len, input int first);
        logic d;
        for (int s = first; s < len; s++) begin
            if (s >= 1 && s <= W) d = w[W-s];
            else d = 1'($urandom_range(0, 1));
            send_slot(lr, d);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int llen, input int rlen);
        send_half(1'b0, l, llen, 0);
        send_half(1'b1, r, rlen, 0);
    endtask

    task automatic begin_stream();
        @(posedge clk_i); #1 enable_i = 1'b0;
        send_half(1'b1, 24'($urandom()), HALF, 0);
        @(posedge clk_i); #1 enable_i = 1'b1;
    endtask

    // The falling LRCLK edge that starts the next left half publishes the last pair.
    task automatic end_stream();
        send_half(1'b0, 24'($urandom()), 4, 0);
        repeat (20) @(posedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b1; ready_i = 1'b1;
        audio_bclk_i = 1'b1; audio_lrclk_i = 1'b1; audio_data_i = 1'b0;
        repeat (5) @(negedge clk_i);
        checks++; if (left_o !== 24'h0) begin errors++; $display("FAIL reset_left: got %h expected 0", left_o); end
        checks++; if (right_o !== 24'h0) begin errors++; $display("FAIL reset_right: got %h expected 0", right_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        @(posedge clk_i); #1 rst_i = 1'b0;
        clear_obs();
    endtask

    task automatic test_alignment();
        logic [2*W-1:0] g;
        clear_obs();
        begin_stream();
        send_frame(24'h800001, 24'h7FFFFE, HALF, HALF);
        exp_q.push_back({24'h800001, 24'h7FFFFE});
        send_frame(24'h9A5AC3, 24'h9A5AC3, HALF, HALF);
        exp_q.push_back({24'h9A5AC3, 24'h9A5AC3});
        end_stream();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL align_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL align_pair[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL align_frame_err: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_overrun();
        logic [2*W-1:0] g;
        logic [W-1:0] al, ar, dl, dr;
        al = 24'($urandom()); ar = 24'($urandom());
        dl = 24'($urandom()); dr = 24'($urandom());
        clear_obs();
        @(posedge clk_i); #1 ready_i = 1'b0;
        begin_stream();
        send_frame(al, ar, HALF, HALF);
        send_frame(24'($urandom()), 24'($urandom()), HALF, HALF);
        send_frame(24'($urandom()), 24'($urandom()), HALF, HALF);
        send_half(1'b0, dl, 1, 0);
        repeat (10) @(negedge clk_i);
        checks++; if (ovr_cnt != 2) begin errors++; $display("FAIL ovr_count: got %0d expected 2", ovr_cnt); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", valid_o); end
        checks++; if ({left_o, right_o} !== {al, ar}) begin errors++; $display("FAIL ovr_held_pair: got %h expected %h", {left_o, right_o}, {al, ar}); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_no_transfer: got %0d expected 0", got_q.size()); end
        @(posedge clk_i); #1 ready_i = 1'b1;
        exp_q.push_back({al, ar});
        exp_q.push_back({dl, dr});
        send_half(1'b0, dl, HALF, 1);
        send_half(1'b1, dr, HALF, 0);
        end_stream();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_transfers: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL ovr_pair[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        checks++; if (ovr_cnt != 2) begin errors++; $display("FAIL ovr_total: got %0d expected 2", ovr_cnt); end
    endtask

    task automatic test_frame_err();
        logic [2*W-1:0] g;
        clear_obs();
        begin_stream();
        send_frame(24'($urandom()), 24'($urandom()), HALF - 2, HALF);
        send_frame(24'h123456, 24'hABCDEF, HALF, HALF);
        exp_q.push_back({24'h123456, 24'hABCDEF});
        end_stream();
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_transfers: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL ferr_pair[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_reset_enable();
        logic [2*W-1:0] g;
        logic [W-1:0] p1l, p1r, p3l, p3r, p4l, p4r;
        p1l = 24'($urandom()); p1r = 24'($urandom());
        p3l = 24'($urandom()); p3r = 24'($urandom());
        p4l = 24'($urandom()); p4r = 24'($urandom());
        clear_obs();
        begin_stream();
        send_frame(p1l, p1r, HALF, HALF);
        exp_q.push_back({p1l, p1r});
        send_half(1'b0, 24'($urandom()), HALF, 0);
        send_half(1'b1, 24'($urandom()), 16, 0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid_o); end
        checks++; if (left_o !== 24'h0) begin errors++; $display("FAIL rst_mid_left: got %h expected 0", left_o); end
        @(posedge clk_i); #1 rst_i = 1'b0;
        send_half(1'b1, 24'($urandom()), HALF, 16);
        @(posedge clk_i); #1 enable_i = 1'b0;
        valid_hi = 0;
        send_frame(24'($urandom()), 24'($urandom()), HALF, HALF);
        send_half(1'b0, 24'($urandom()), HALF, 0);
        send_half(1'b1, 24'($urandom()), 10, 0);
        checks++; if (valid_hi != 0) begin errors++; $display("FAIL disabled_valid: got %0d cycles expected 0", valid_hi); end
        @(posedge clk_i); #1 enable_i = 1'b1;
        send_half(1'b1, 24'($urandom()), HALF, 10);
        send_frame(p3l, p3r, HALF, HALF);
        exp_q.push_back({p3l, p3r});
        send_frame(p4l, p4r, HALF, HALF);
        exp_q.push_back({p4l, p4r});
        end_stream();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reen_transfers: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL reen_pair[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL reen_frame_err: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_random_stream();
        logic [2*W-1:0] g;
        logic [W-1:0] l, r;
        bit done;
        clear_obs();
        done = 1'b0;
        fork
            begin
                begin_stream();
                for (int n = 0; n < 100; n++) begin
                    l = 24'($urandom());
                    r = 24'($urandom());
                    exp_q.push_back({l, r});
                    send_frame(l, r, HALF, HALF);
                end
                end_stream();
                done = 1'b1;
            end
            begin
                // Short consumer stalls, always shorter than one frame.
                while (!done) begin
                    @(posedge clk_i); #1 ready_i = 1'b0;
                    repeat ($urandom_range(1, 20)) @(posedge clk_i);
                    #1 ready_i = 1'b1;
                    repeat ($urandom_range(1, 40)) @(posedge clk_i);
                end
            end
        join
        @(posedge clk_i); #1 ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_transfers: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL rand_pair[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL rand_overrun: got %0d expected 0", ovr_cnt); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL rand_frame_err: got %0d expected 0", ferr_cnt); end
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_overrun();
        test_frame_err();
        test_reset_enable();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
